data_mem_block_mover: RTL and testbench
=======================================

// Module: data_mem_block_mover
// PURPOSE
//  Bus initiator for the 16-bit data memory: copies a block of LEN words from
//  SRC to DST by alternating single-word reads and writes on the memory's
//  shared address port. Sits beside the CPU datapath as a small DMA engine;
//  the CPU starts a transfer with a one-cycle pulse and polls busy/done/err.
// PARAMETERS
//  DEPTH  8   number of words in data memory; valid word addresses 0..DEPTH-1
//  LEN_W  4   width of the len port (max block 2**LEN_W-1 words)
// PORTS
//  clk              in   1      system clock, all state on posedge
//  rst_n            in   1      synchronous reset, active low
//  start            in   1      one-cycle request; sampled only in IDLE
//  src_addr         in   16     first source word address (sampled with start)
//  dst_addr         in   16     first destination word address (sampled with start)
//  len              in   LEN_W  word count (sampled with start)
//  busy             out  1      high in READ/WRITE/DONE
//  done             out  1      one-cycle pulse when the transfer ends (ok or err)
//  err              out  1      range violation on last request; sticky
//  words_done       out  LEN_W  words written so far in the current transfer
//  mem_access_addr  out  16     memory address, shared by read and write
//  mem_write_data   out  16     memory write data
//  mem_write_en     out  1      memory write strobe (memory writes on posedge)
//  mem_read         out  1      memory read enable (combinational read data)
//  mem_read_data    in   16     memory read data, valid same cycle as mem_read
// BEHAVIOUR
//  - Reset (rst_n low at posedge): state=IDLE, busy=0, done=0, err=0,
//    words_done=0, data buffer=0. mem_read and mem_write_en are gated by
//    rst_n combinationally: no memory access in any cycle rst_n is low.
//  - FSM states IDLE, READ, WRITE, DONE.
//  - IDLE: addr/data outputs 0, strobes 0. On start: latch src, dst, len;
//    clear words_done, clear err. Range check on 17-bit sums:
//    src+len > DEPTH or dst+len > DEPTH -> set err, go DONE (no accesses).
//    len==0 and in range -> DONE. Else -> READ.
//  - READ: mem_access_addr=src+words_done, mem_read=1; at posedge capture
//    mem_read_data into buffer, -> WRITE.
//  - WRITE: mem_access_addr=dst+words_done, mem_write_data=buffer,
//    mem_write_en=1; at posedge words_done++; if words_done+1==len -> DONE
//    else -> READ.
//  - DONE: done=1 for exactly this cycle, strobes 0; -> IDLE.
//  - Latency: accepted start to done pulse = 2*len+1 cycles (1 for len=0/err).
//  - Address arithmetic 16-bit, no wrap needed (range check precludes it).
//  - Copy is strictly ascending, one word at a time; overlapping regions with
//    dst>src propagate already-copied words (defined, not an error).
//  - start while busy is ignored; inputs while busy are not re-sampled.
//  - mem_read and mem_write_en are never high in the same cycle.
//  - err holds until the next accepted start; done does not hold.
// TESTING
//  1 Reset: rst_n=0 two cycles in WRITE -> no write strobe, all outputs 0, IDLE.
//  2 mem={A,B,C,..}, start src=0 dst=4 len=3 -> mem[4..6]=A,B,C; done at
//    cycle 7 after start; words_done=3; err=0; strobes alternate R,W.
//  3 start len=0 src=2 dst=3 -> done next cycle, no strobes, memory unchanged.
//  4 start src=6 dst=0 len=3 -> err=1 with done after 1 cycle, no accesses;
//    next valid start clears err.
//  5 start while busy (second start with dst=1) -> ignored, first copy intact.
//  6 rst_n low in mid-copy (after 1 word) -> only word 0 written, IDLE,
//    busy=0; fresh start then completes normally.

Source files
------------

// File: rtl/data_mem_block_mover.sv
// rtl/data_mem_block_mover.sv - single-port data memory block copy engine (read/write alternating)
module data_mem_block_mover #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      src_addr,
  input  logic [15:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  output logic [15:0]      mem_access_addr,
  output logic [15:0]      mem_write_data,
  output logic             mem_write_en,
  output logic             mem_read,
  input  logic [15:0]      mem_read_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [15:0]      src_q;
  logic [15:0]      dst_q;
  logic [15:0]      buffer;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] wd_q;
  logic [LEN_W-1:0] wd_next;
  logic             err_q;
  logic [16:0]      src_end;
  logic [16:0]      dst_end;
  logic             out_of_range;

  // 17-bit sums so a block near the top of the 16-bit space cannot wrap into range
  assign src_end      = {1'b0, src_addr} + 17'(len);
  assign dst_end      = {1'b0, dst_addr} + 17'(len);
  assign out_of_range = (src_end > 17'(DEPTH)) || (dst_end > 17'(DEPTH));
  assign wd_next      = wd_q + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      wd_q   <= '0;
      buffer <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            len_q <= len;
            wd_q  <= '0;
            err_q <= out_of_range;
            if (out_of_range || (len == '0)) state <= S_DONE;
            else                             state <= S_READ;
          end
        end
        S_READ: begin
          buffer <= mem_read_data;
          state  <= S_WRITE;
        end
        S_WRITE: begin
          wd_q  <= wd_next;
          state <= (wd_next == len_q) ? S_DONE : S_READ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are qualified by rst_n so a reset asserted mid-transfer never touches memory
  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    case (state)
      S_READ: begin
        mem_access_addr = src_q + 16'(wd_q);
        mem_read        = rst_n;
      end
      S_WRITE: begin
        mem_access_addr = dst_q + 16'(wd_q);
        mem_write_data  = buffer;
        mem_write_en    = rst_n;
      end
      default: ;
    endcase
  end

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign err        = err_q;
  assign words_done = wd_q;

endmodule

// File: tb/tb_data_mem_block_mover.sv
// tb/tb_data_mem_block_mover.sv - directed table-driven bench for data_mem_block_mover
module tb_data_mem_block_mover;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [3:0]  len;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  words_done;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [15:0] mem_read_data;

  always #5 clk = ~clk;

  data_mem_block_mover #(.DEPTH(8), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .err(err), .words_done(words_done),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  logic [15:0] mem [8];
  logic [15:0] img [8];
  logic        do_init;
  int          rd_cnt, wr_cnt, overlap_cnt, seq_err;
  logic        last_rd;
  int          errors = 0;
  int          checks = 0;

  assign mem_read_data = (mem_read && mem_access_addr < 16'd8) ? mem[mem_access_addr[2:0]] : 16'h0;

  // Memory model plus strobe monitor: alternation, overlap, out-of-range writes
  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 8; i++) mem[i] <= img[i];
      rd_cnt <= 0; wr_cnt <= 0; overlap_cnt <= 0; seq_err <= 0; last_rd <= 1'b0;
    end else begin
      if (mem_write_en) begin
        if (mem_access_addr < 16'd8) mem[mem_access_addr[2:0]] <= mem_write_data;
        else seq_err <= seq_err + 1;
      end
      if (mem_read) rd_cnt <= rd_cnt + 1;
      if (mem_write_en) wr_cnt <= wr_cnt + 1;
      if (mem_read && mem_write_en) overlap_cnt <= overlap_cnt + 1;
      if (mem_read) begin
        if (last_rd) seq_err <= seq_err + 1;
        last_rd <= 1'b1;
      end else if (mem_write_en) begin
        if (!last_rd) seq_err <= seq_err + 1;
        last_rd <= 1'b0;
      end
    end
  end

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [3:0]  len;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mem();
    do_init = 1'b1;
    tick();
    do_init = 1'b0;
  endtask

  task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [3:0] l);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] model [8];
    int n;
    int bad;
    load_mem();
    issue(v.src, v.dst, v.len);
    check($sformatf("v%0d_err_at_accept", idx), 32'(err), 32'(v.err));
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check($sformatf("v%0d_latency", idx), 32'(n), 32'(v.lat));
    check($sformatf("v%0d_words_done", idx), 32'(words_done), v.err ? 32'd0 : 32'(v.len));
    check($sformatf("v%0d_err_at_done", idx), 32'(err), 32'(v.err));
    tick();
    check($sformatf("v%0d_done_cleared", idx), 32'(done), 32'd0);
    check($sformatf("v%0d_busy_cleared", idx), 32'(busy), 32'd0);
    check($sformatf("v%0d_err_sticky", idx), 32'(err), 32'(v.err));
    check($sformatf("v%0d_reads", idx), 32'(rd_cnt), v.err ? 32'd0 : 32'(v.len));
    check($sformatf("v%0d_writes", idx), 32'(wr_cnt), v.err ? 32'd0 : 32'(v.len));
    check($sformatf("v%0d_strobe_order", idx), 32'(overlap_cnt + seq_err), 32'd0);
    for (int i = 0; i < 8; i++) model[i] = img[i];
    if (!v.err)
      for (int i = 0; i < int'(v.len); i++) model[v.dst + 16'(i)] = model[v.src + 16'(i)];
    bad = 0;
    for (int i = 0; i < 8; i++) if (mem[i] !== model[i]) bad++;
    check($sformatf("v%0d_mem_words_wrong", idx), 32'(bad), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++) img[i] = 16'h1111 * 16'(i + 1);
    vecs[0] = '{src: 16'd0, dst: 16'd4, len: 4'd3, err: 1'b0, lat: 7};
    vecs[1] = '{src: 16'd2, dst: 16'd3, len: 4'd0, err: 1'b0, lat: 1};
    vecs[2] = '{src: 16'd6, dst: 16'd0, len: 4'd3, err: 1'b1, lat: 1};
    vecs[3] = '{src: 16'd0, dst: 16'd1, len: 4'd4, err: 1'b0, lat: 9};
    vecs[4] = '{src: 16'd1, dst: 16'd0, len: 4'd8, err: 1'b1, lat: 1};
    vecs[5] = '{src: 16'd5, dst: 16'd0, len: 4'd3, err: 1'b0, lat: 7};
    vecs[6] = '{src: 16'hFFFF, dst: 16'd0, len: 4'd1, err: 1'b1, lat: 1};
    vecs[7] = '{src: 16'd0, dst: 16'd0, len: 4'd8, err: 1'b0, lat: 17};

    rst_n = 1'b0; start = 1'b0; do_init = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_words_done", 32'(words_done), 32'd0);
    check("reset_strobes", {30'd0, mem_read, mem_write_en}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset asserted while the second word's write is on the bus
    load_mem();
    issue(16'd0, 16'd4, 4'd3);
    tick();
    tick();
    tick();
    check("midreset_in_write", 32'(mem_write_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_strobes_gated", {30'd0, mem_read, mem_write_en}, 32'd0);
    tick();
    tick();
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_words_done", 32'(words_done), 32'd0);
    check("midreset_addr", 32'(mem_access_addr), 32'd0);
    check("midreset_word0", 32'(mem[4]), 32'(img[0]));
    check("midreset_word1_untouched", 32'(mem[5]), 32'(img[5]));
    check("midreset_write_count", 32'(wr_cnt), 32'd1);
    rst_n = 1'b1;
    tick();
    run_vec(vecs[0], 10);

    // Second start while busy must be ignored
    load_mem();
    issue(16'd0, 16'd4, 4'd3);
    n = 1;
    tick(); n++;
    tick(); n++;
    src_addr = 16'd2; dst_addr = 16'd1; len = 4'd2; start = 1'b1;
    tick(); n++;
    start = 1'b0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("busy_start_latency", 32'(n), 32'd7);
    check("busy_start_words_done", 32'(words_done), 32'd3);
    tick();
    check("busy_start_dst1_intact", 32'(mem[1]), 32'(img[1]));
    check("busy_start_copy4", 32'(mem[4]), 32'(img[0]));
    check("busy_start_copy6", 32'(mem[6]), 32'(img[2]));
    check("busy_start_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
